// File: rtl/perf_sample_sequencer_if.sv
// Record stream between the sample sequencer and the trace writer.
//
// Handshake: a word moves on a rising clk_i edge when rec_valid_o and
// rec_ready_i are both high. Once rec_valid_o is raised, it stays high and
// rec_data_o/rec_tag_o/rec_last_o stay constant until that word moves.
// rec_ready_i may change freely and never depends on rec_valid_o.
//
// Signals:
//   rec_valid_o   record word valid (master -> slave)
//   rec_ready_i   sink accepts word (slave -> master)
//   rec_data_o    record word, CNT_W bits
//   rec_tag_o     word index within the record, 0..6
//   rec_last_o    high together with tag 6
//   fsm_state_dbg sequencer state, 0 = IDLE, 1 = SEND (observation only)
interface perf_sample_sequencer_if #(
    parameter int CNT_W = 32
);
    logic             rec_valid_o;
    logic             rec_ready_i;
    logic [CNT_W-1:0] rec_data_o;
    logic [2:0]       rec_tag_o;
    logic             rec_last_o;
    logic             fsm_state_dbg;

    modport master (
        output rec_valid_o,
        input  rec_ready_i,
        output rec_data_o,
        output rec_tag_o,
        output rec_last_o,
        output fsm_state_dbg
    );

    modport slave (
        input  rec_valid_o,
        output rec_ready_i,
        input  rec_data_o,
        input  rec_tag_o,
        input  rec_last_o,
        input  fsm_state_dbg
    );
endinterface

// File: rtl/perf_sample_sequencer.sv
// Periodically snapshots the six retirement-statistics counters and sends
// each snapshot as a 7-word record (seq, cycle, retire, alu, load, store,
// branch) over the record stream. A sample is triggered every
// SAMPLE_INTERVAL cycles while enable_i is high, or by a dump_req_i pulse.
// Triggers that arrive while a record is still draining are dropped and
// counted in a saturating overrun counter.
//
// Ports:
//   clk_i          clock, all logic on posedge
//   reset_i        synchronous active-high reset
//   enable_i       enables periodic sampling
//   dump_req_i     single-cycle manual snapshot request
//   *_cnt_i        live counters (cycle, retire, alu, load, store, branch)
//   rec            record stream (master side)
//   busy_o         high while a record is being sent
//   overrun_cnt_o  dropped-trigger count, saturating
module perf_sample_sequencer #(
    parameter int SAMPLE_INTERVAL = 1000,
    parameter int CNT_W           = 32,
    parameter int OVR_W           = 16
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      enable_i,
    input  logic                      dump_req_i,
    input  logic [CNT_W-1:0]          cycle_cnt_i,
    input  logic [CNT_W-1:0]          retire_cnt_i,
    input  logic [CNT_W-1:0]          alu_cnt_i,
    input  logic [CNT_W-1:0]          load_cnt_i,
    input  logic [CNT_W-1:0]          store_cnt_i,
    input  logic [CNT_W-1:0]          branch_cnt_i,
    perf_sample_sequencer_if.master   rec,
    output logic                      busy_o,
    output logic [OVR_W-1:0]          overrun_cnt_o
);

    localparam int IW = (SAMPLE_INTERVAL > 2) ? $clog2(SAMPLE_INTERVAL) : 1;
    localparam logic [IW-1:0] LAST_CNT = IW'(SAMPLE_INTERVAL - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    int_cnt_q;
    logic [CNT_W-1:0] seq_q;
    logic [CNT_W-1:0] snap_q [7];
    logic [2:0]       tag_q;
    logic [OVR_W-1:0] ovr_q;

    logic tick, trigger, xfer, last_xfer, take_snap, drop;

    // Interval counter runs regardless of FSM state.
    assign tick      = enable_i && (int_cnt_q == LAST_CNT);
    assign trigger   = tick || dump_req_i;
    assign xfer      = rec.rec_valid_o && rec.rec_ready_i;
    assign last_xfer = xfer && (tag_q == 3'd6);

    always_ff @(posedge clk_i) begin
        if (reset_i || !enable_i || tick) begin
            int_cnt_q <= '0;
        end else begin
            int_cnt_q <= int_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A trigger is accepted only in IDLE or on the final handshake of a
    // record; the latter chains a new record with no bubble.
    always_comb begin
        state_d   = state_q;
        take_snap = 1'b0;
        drop      = 1'b0;
        case (state_q)
            IDLE: begin
                if (trigger) begin
                    take_snap = 1'b1;
                    state_d   = SEND;
                end
            end
            SEND: begin
                if (last_xfer) begin
                    if (trigger) begin
                        take_snap = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (trigger) begin
                    drop = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            seq_q <= '0;
            tag_q <= '0;
            ovr_q <= '0;
            for (int i = 0; i < 7; i++) begin
                snap_q[i] <= '0;
            end
        end else begin
            if (take_snap) begin
                snap_q[0] <= seq_q;
                snap_q[1] <= cycle_cnt_i;
                snap_q[2] <= retire_cnt_i;
                snap_q[3] <= alu_cnt_i;
                snap_q[4] <= load_cnt_i;
                snap_q[5] <= store_cnt_i;
                snap_q[6] <= branch_cnt_i;
                seq_q     <= seq_q + 1'b1;
                tag_q     <= '0;
            end else if (xfer) begin
                tag_q <= (tag_q == 3'd6) ? 3'd0 : tag_q + 3'd1;
            end
            if (drop && (ovr_q != {OVR_W{1'b1}})) begin
                ovr_q <= ovr_q + 1'b1;
            end
        end
    end

    always_comb begin
        rec.rec_valid_o   = (state_q == SEND);
        rec.rec_tag_o     = tag_q;
        rec.rec_last_o    = (state_q == SEND) && (tag_q == 3'd6);
        rec.rec_data_o    = '0;
        rec.fsm_state_dbg = state_q;
        if (state_q == SEND) begin
            case (tag_q)
                3'd0:    rec.rec_data_o = snap_q[0];
                3'd1:    rec.rec_data_o = snap_q[1];
                3'd2:    rec.rec_data_o = snap_q[2];
                3'd3:    rec.rec_data_o = snap_q[3];
                3'd4:    rec.rec_data_o = snap_q[4];
                3'd5:    rec.rec_data_o = snap_q[5];
                3'd6:    rec.rec_data_o = snap_q[6];
                default: rec.rec_data_o = '0;
            endcase
        end
    end

    assign busy_o        = (state_q == SEND);
    assign overrun_cnt_o = ovr_q;

endmodule

// File: tb/tb_perf_sample_sequencer.sv
module tb_perf_sample_sequencer;
    localparam int SI    = 10;
    localparam int CNT_W = 32;
    localparam int OVR_W = 4;
    localparam int OVR_MAX = (1 << OVR_W) - 1;

    // ---------------- clock / reset ----------------
    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic             reset_i = 1'b1;
    logic             enable_i = 1'b0;
    logic             dump_req_i = 1'b0;
    logic [CNT_W-1:0] cnt [6];
    logic             busy_o;
    logic [OVR_W-1:0] overrun_cnt_o;

    perf_sample_sequencer_if #(.CNT_W(CNT_W)) bus ();

    perf_sample_sequencer #(
        .SAMPLE_INTERVAL(SI),
        .CNT_W(CNT_W),
        .OVR_W(OVR_W)
    ) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .enable_i     (enable_i),
        .dump_req_i   (dump_req_i),
        .cycle_cnt_i  (cnt[0]),
        .retire_cnt_i (cnt[1]),
        .alu_cnt_i    (cnt[2]),
        .load_cnt_i   (cnt[3]),
        .store_cnt_i  (cnt[4]),
        .branch_cnt_i (cnt[5]),
        .rec          (bus.master),
        .busy_o       (busy_o),
        .overrun_cnt_o(overrun_cnt_o)
    );

    // ---------------- scoreboard / reference model ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [CNT_W-1:0] exp_q[$];

    // Model: the record currently on the wire (7 words), position in it,
    // samples taken so far, cycles since last periodic sample, drops.
    bit               m_send;
    logic [CNT_W-1:0] m_rec [7];
    int               m_pos;
    logic [CNT_W-1:0] m_seq;
    int               m_phase;
    int               m_ovr;

    // Observations of the cycle most recently checked by step().
    logic             obs_valid, obs_busy;
    logic [2:0]       obs_tag;
    logic [CNT_W-1:0] obs_data;

    task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_send = 0; m_pos = 0; m_seq = '0; m_phase = 0; m_ovr = 0;
        for (int i = 0; i < 7; i++) m_rec[i] = '0;
        exp_q.delete();
    endtask

    task automatic model_sample();
        m_rec[0] = m_seq;
        for (int i = 0; i < 6; i++) m_rec[i+1] = cnt[i];
        m_seq  = m_seq + 1;
        m_pos  = 0;
        m_send = 1;
        for (int i = 0; i < 7; i++) exp_q.push_back(m_rec[i]);
    endtask

    // One clock cycle: check outputs against the model, then advance the
    // model with the inputs the caller has set up for this cycle.
    task automatic step();
        bit trig;
        @(negedge clk_i);
        obs_valid = bus.rec_valid_o;
        obs_busy  = busy_o;
        obs_tag   = bus.rec_tag_o;
        obs_data  = bus.rec_data_o;
        check_eq("valid", 64'(bus.rec_valid_o), 64'(m_send));
        check_eq("busy",  64'(busy_o), 64'(m_send));
        check_eq("tag",   64'(bus.rec_tag_o), m_send ? 64'(m_pos) : 64'd0);
        check_eq("last",  64'(bus.rec_last_o), 64'(m_send && m_pos == 6));
        check_eq("data",  64'(bus.rec_data_o), m_send ? 64'(m_rec[m_pos]) : 64'd0);
        check_eq("ovr",   64'(overrun_cnt_o), 64'(m_ovr));
        if (m_send && bus.rec_ready_i) begin
            if (exp_q.size() == 0) check_eq("sb_empty", 64'd1, 64'd0);
            else check_eq("sb_word", 64'(bus.rec_data_o), 64'(exp_q.pop_front()));
        end
        if (reset_i) begin
            model_reset();
        end else begin
            trig = dump_req_i || (enable_i && m_phase == SI - 1);
            if (!m_send) begin
                if (trig) model_sample();
            end else if (bus.rec_ready_i && m_pos == 6) begin
                if (trig) model_sample();
                else m_send = 0;
            end else begin
                if (bus.rec_ready_i) m_pos++;
                if (trig && m_ovr < OVR_MAX) m_ovr++;
            end
            m_phase = enable_i ? (m_phase + 1) % SI : 0;
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
    endtask

    task automatic drain();
        enable_i = 0; dump_req_i = 0; bus.rec_ready_i = 1;
        repeat (12) step();
    endtask

    // ---------------- stimulus ----------------
    initial begin : main
        int first, span, valid_cnt;
        logic [CNT_W-1:0] prev, t2_exp [7];
        bus.rec_ready_i = 1'b0;
        for (int i = 0; i < 6; i++) cnt[i] = '0;
        repeat (2) @(posedge clk_i);
        #1;
        model_reset();
        reset_i = 1'b0;

        // Periodic sampling: first record at cycle 10, second at 20.
        enable_i = 1; bus.rec_ready_i = 1;
        first = -1;
        for (int k = 0; k < 40; k++) begin
            step();
            if (k == 0) check_eq("reset_valid", 64'(obs_valid), 64'd0);
            if (obs_valid) begin first = k; break; end
        end
        check_eq("first_rec_cycle", 64'(first), 64'd10);
        check_eq("rec1_seq", 64'(obs_data), 64'd0);
        for (int k = 11; k <= 20; k++) step();
        check_eq("rec2_tag", 64'(obs_tag), 64'd0);
        check_eq("rec2_seq", 64'(obs_data), 64'd1);
        drain();

        // Manual dump with known inputs; inputs wiggle during SEND.
        do_reset();
        cnt[0] = 'h64; cnt[1] = 'h20; cnt[2] = 'h10; cnt[3] = 4; cnt[4] = 3; cnt[5] = 5;
        t2_exp[0] = 0; for (int i = 0; i < 6; i++) t2_exp[i+1] = cnt[i];
        dump_req_i = 1; step(); dump_req_i = 0;
        for (int i = 0; i < 7; i++) begin
            for (int j = 0; j < 6; j++) cnt[j] = $urandom;
            step();
            check_eq("t2_word", 64'(obs_data), 64'(t2_exp[i]));
        end

        // Backpressure at tag 2 for 5 cycles.
        drain();
        dump_req_i = 1; step(); dump_req_i = 0;
        span = 0;
        for (int k = 0; k < 40; k++) begin
            bus.rec_ready_i = !(span >= 2 && span < 7);
            step();
            if (obs_valid) begin
                if (span >= 2 && span < 7) check_eq("t3_hold_tag", 64'(obs_tag), 64'd2);
                span++;
            end else if (span > 0) break;
        end
        check_eq("t3_span", 64'(span), 64'd12);

        // Drops during SEND, then saturation.
        drain();
        do_reset();
        dump_req_i = 1; step(); dump_req_i = 0;
        for (int i = 0; i < 7; i++) begin
            dump_req_i = (i == 1 || i == 4);
            step();
        end
        dump_req_i = 0;
        valid_cnt = 0;
        for (int i = 0; i < 5; i++) begin step(); if (obs_valid) valid_cnt++; end
        check_eq("t4_one_record", 64'(valid_cnt), 64'd0);
        check_eq("t4_ovr", 64'(overrun_cnt_o), 64'd2);
        dump_req_i = 1; step();
        bus.rec_ready_i = 0;
        repeat (20) step();
        dump_req_i = 0; step();
        check_eq("t4_ovr_sat", 64'(overrun_cnt_o), 64'(OVR_MAX));
        drain();

        // Back-to-back record on the final handshake.
        dump_req_i = 1; step(); dump_req_i = 0;
        for (int i = 0; i < 7; i++) begin
            dump_req_i = (i == 6);
            step();
            if (i == 0) prev = obs_data;
        end
        dump_req_i = 0;
        step();
        check_eq("t5_b2b_valid", 64'(obs_valid), 64'd1);
        check_eq("t5_b2b_tag", 64'(obs_tag), 64'd0);
        check_eq("t5_b2b_seq", 64'(obs_data), 64'(prev + 1));
        drain();

        // Tick coinciding with dump in IDLE gives one record.
        do_reset();
        enable_i = 1;
        repeat (9) step();
        dump_req_i = 1; step(); dump_req_i = 0;
        valid_cnt = 0;
        for (int k = 10; k < 20; k++) begin step(); if (obs_valid) valid_cnt++; end
        check_eq("t5_coincide_cnt", 64'(valid_cnt), 64'd7);
        drain();

        // Reset in the middle of a record.
        dump_req_i = 1; step(); dump_req_i = 0;
        repeat (3) step();
        reset_i = 1; step(); reset_i = 0;
        check_eq("t6_tag_at_reset", 64'(obs_tag), 64'd3);
        step();
        check_eq("t6_valid", 64'(obs_valid), 64'd0);
        check_eq("t6_busy", 64'(obs_busy), 64'd0);
        dump_req_i = 1; step(); dump_req_i = 0;
        step();
        check_eq("t6_seq", 64'(obs_data), 64'd0);
        drain();

        // Randomized traffic.
        for (int k = 0; k < 3000; k++) begin
            reset_i         = ($urandom_range(0, 499) == 0);
            enable_i        = ($urandom_range(0, 9) != 0);
            dump_req_i      = ($urandom_range(0, 14) == 0);
            bus.rec_ready_i = ($urandom_range(0, 9) < 7);
            for (int j = 0; j < 6; j++) cnt[j] = $urandom;
            step();
        end
        reset_i = 0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/perf_sample_sequencer.md
Name: perf_sample_sequencer

Overview:
Controller that periodically snapshots the retirement-statistics counters (cycle, retired, ALU, load, store, branch) and serializes each snapshot as a 7-word record over a valid/ready stream to a log sink. Sits in the bench between the cycle/retire counting logic and the trace writer. Sequences sampling at a fixed cycle interval or on explicit request. Counts triggers dropped while a record is still draining.

Parameters:
SAMPLE_INTERVAL, 1000, cycles between periodic samples; legal range >= 2
CNT_W, 32, width of every input counter and of rec_data_o
OVR_W, 16, width of overrun counter

Ports:
clk_i  in  1  clock; all logic on posedge
reset_i  in  1  synchronous, active-high reset
enable_i  in  1  enables periodic sampling
dump_req_i  in  1  single-cycle manual snapshot request
cycle_cnt_i  in  CNT_W  live cycle count
retire_cnt_i  in  CNT_W  live retired-instruction count
alu_cnt_i  in  CNT_W  live ALU-op count
load_cnt_i  in  CNT_W  live load count
store_cnt_i  in  CNT_W  live store count
branch_cnt_i  in  CNT_W  live branch/jump count
rec_valid_o  out  1  record word valid
rec_ready_i  in  1  sink accepts word
rec_data_o  out  CNT_W  record word
rec_tag_o  out  3  word index in record, 0..6
rec_last_o  out  1  high with tag 6
busy_o  out  1  high while in SEND
overrun_cnt_o  out  OVR_W  dropped-trigger count, saturating

Behaviour:
- Reset: state IDLE, interval counter 0, seq counter 0, rec_valid_o 0, rec_tag_o 0, rec_last_o 0, rec_data_o 0, busy_o 0, overrun_cnt_o 0. Reset mid-record abandons it; rec_valid_o is low in the cycle after the reset edge.
- Interval counter: while enable_i=1, counts 0..SAMPLE_INTERVAL-1 and wraps. Periodic trigger (tick) asserts combinationally in the cycle the counter equals SAMPLE_INTERVAL-1. While enable_i=0, the counter is forced to 0 and there is no tick. The counter runs independently of FSM state.
- trigger = tick OR dump_req_i. Coincident tick and dump_req_i produce a single trigger.
- FSM states are IDLE and SEND.
- IDLE + trigger at edge T:
  - Latch all six inputs into snapshot registers.
  - Latch the seq counter into the header, then increment seq (wraps mod 2^CNT_W).
  - Set tag=0, go to SEND. rec_valid_o and busy_o are high from T+1.
- SEND:
  - rec_data_o is the snapshot word selected by tag: 0=seq, 1=cycle, 2=retire, 3=alu, 4=load, 5=store, 6=branch.
  - rec_last_o = (tag==6).
  - A transfer occurs when rec_valid_o & rec_ready_i; tag then advances.
  - While rec_ready_i=0, data/tag/last are held stable and valid stays high.
- Last word accepted (tag 6 handshake):
  - No trigger in the same cycle: go to IDLE, valid low next cycle.
  - Trigger in the same cycle: take a new snapshot, stay in SEND with tag=0 and valid continuously high (back-to-back records, no bubble).
- Trigger in SEND other than during the final handshake: dropped, no snapshot taken, overrun_cnt_o increments by 1 and saturates at 2^OVR_W-1.
- Snapshot registers are isolated from live inputs during SEND; input changes never alter an in-flight record.
- Minimum record duration is 7 cycles with rec_ready_i held high.

Test Plan:
1. SAMPLE_INTERVAL=10, enable_i=1 after reset, rec_ready_i=1 -> first record valid at cycle 10 (counter hits 9 at cycle 9). Tags 0..6 on consecutive cycles, word0=0, rec_last_o only with tag 6, second record word0=1 at cycle 20.
2. dump_req_i pulse in IDLE with enable_i=0 and inputs cycle=0x64, retire=0x20, alu=0x10, load=4, store=3, branch=5 -> words 0,0x64,0x20,0x10,4,3,5. Inputs changed during SEND do not appear in the words.
3. rec_ready_i held 0 for 5 cycles at tag 2 -> valid stays high, data/tag frozen for 5 cycles, tag 3 appears after ready rises. Total record span 12 cycles.
4. Two dump_req_i pulses during SEND (tags 1 and 4) -> overrun_cnt_o = 2, only one record emitted. Force 0xFFFF then another drop -> stays 0xFFFF.
5. dump_req_i in the same cycle as the tag-6 handshake -> next cycle valid=1, tag=0, word0=previous seq+1, no idle gap. Tick coinciding with dump_req_i in IDLE -> exactly one record.
6. Assert reset_i during tag 3 -> rec_valid_o=0, busy_o=0, overrun_cnt_o=0 next cycle. The next record's word0=0.
